// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order-retire reorder buffer with CDB capture and flush
//
// Purpose:
//   Allocates one entry per decoded instruction at the tail, captures results
//   broadcast on the common data bus, and retires entries strictly in program
//   order from the head onto the register-file write-back port. A retiring
//   mispredicted branch empties the buffer and raises a one-cycle flush.
//
// Configuration:
//   ROB_BYPASS_EN - when defined, builds the Q1/Q2 operand query ports with
//                   same-cycle CDB forwarding; otherwise they are tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global enable; 0 freezes all architectural state
//   ID_alloc_*          allocation request and destination register
//   ROB_alloc_tag       tag the next allocation receives (tail pointer)
//   ROB_full            buffer holds ROB_SIZE entries
//   CDB_*               result broadcast (tag, data, mispredict, target PC)
//   Q1_*, Q2_*          dispatch operand queries
//   ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data   registered commit port
//   ROB_flush, ROB_flush_pc                           registered redirect
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             ID_alloc_valid,
    input  logic [4:0]       ID_alloc_reg_dest,
    output logic [TAG_W-1:0] ROB_alloc_tag,
    output logic             ROB_full,
    input  logic             CDB_valid,
    input  logic [TAG_W-1:0] CDB_tag,
    input  logic [31:0]      CDB_data,
    input  logic             CDB_mispredict,
    input  logic [31:0]      CDB_target_pc,
    input  logic [TAG_W-1:0] Q1_tag,
    input  logic [TAG_W-1:0] Q2_tag,
    output logic             Q1_ready,
    output logic             Q2_ready,
    output logic [31:0]      Q1_data,
    output logic [31:0]      Q2_data,
    output logic             ROB_data_valid,
    output logic [4:0]       ROB_reg_dest,
    output logic [TAG_W-1:0] ROB_tag,
    output logic [31:0]      ROB_data,
    output logic             ROB_flush,
    output logic [31:0]      ROB_flush_pc
);

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(ROB_SIZE);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

    // Per-entry state
    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [ROB_SIZE-1:0] mispred_q;
    logic [4:0]          reg_dest_q [ROB_SIZE];
    logic [31:0]         data_q     [ROB_SIZE];
    logic [31:0]         target_q   [ROB_SIZE];

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    // Registered commit / flush port
    logic             commit_valid_q;
    logic [4:0]       commit_rd_q;
    logic [TAG_W-1:0] commit_tag_q;
    logic [31:0]      commit_data_q;
    logic             flush_q;
    logic [31:0]      flush_pc_q;

    logic full_w;
    logic commit_w;
    logic flush_w;
    logic alloc_w;
    logic cdb_w;

    always_comb begin
        full_w   = (count_q == FULL_CNT);
        commit_w = rdy && busy_q[head_q] && ready_q[head_q];
        flush_w  = commit_w && mispred_q[head_q];
        // Fullness is judged before the commit frees a slot, so a freed slot
        // is never reused on the same edge. A flush drops everything else.
        alloc_w  = rdy && ID_alloc_valid && !full_w && !flush_w;
        cdb_w    = rdy && CDB_valid && busy_q[CDB_tag] && !flush_w;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_w) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_w) head_d = head_q + PTR_ONE;
            if (alloc_w)  tail_d = tail_q + PTR_ONE;
            count_d = count_q + {{TAG_W{1'b0}}, alloc_w} - {{TAG_W{1'b0}}, commit_w};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            ready_q        <= '0;
            mispred_q      <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                reg_dest_q[i] <= '0;
                data_q[i]     <= '0;
                target_q[i]   <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_tag_q   <= '0;
            commit_data_q  <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;

            // Pulses drop on every edge without a commit/flush, rdy=0 included.
            commit_valid_q <= commit_w;
            flush_q        <= flush_w;
            if (commit_w) begin
                commit_rd_q   <= reg_dest_q[head_q];
                commit_tag_q  <= head_q;
                commit_data_q <= data_q[head_q];
            end
            if (flush_w) begin
                flush_pc_q <= target_q[head_q];
            end

            if (flush_w) begin
                busy_q <= '0;
            end else begin
                if (commit_w) begin
                    busy_q[head_q] <= 1'b0;
                end
                if (alloc_w) begin
                    busy_q[tail_q]     <= 1'b1;
                    ready_q[tail_q]    <= 1'b0;
                    mispred_q[tail_q]  <= 1'b0;
                    reg_dest_q[tail_q] <= ID_alloc_reg_dest;
                end
                // The tail entry is never busy when alloc_w is set, so a CDB
                // write cannot collide with the allocation below.
                if (cdb_w) begin
                    ready_q[CDB_tag]   <= 1'b1;
                    mispred_q[CDB_tag] <= CDB_mispredict;
                    data_q[CDB_tag]    <= CDB_data;
                    target_q[CDB_tag]  <= CDB_target_pc;
                end
            end
        end
    end

    assign ROB_alloc_tag  = tail_q;
    assign ROB_full       = full_w;
    assign ROB_data_valid = commit_valid_q;
    assign ROB_reg_dest   = commit_rd_q;
    assign ROB_tag        = commit_tag_q;
    assign ROB_data       = commit_data_q;
    assign ROB_flush      = flush_q;
    assign ROB_flush_pc   = flush_pc_q;

`ifdef ROB_BYPASS_EN
    logic q1_hit;
    logic q2_hit;

    // A result on the CDB this cycle is forwarded so dispatch need not wait
    // for it to land in the entry.
    always_comb begin
        q1_hit   = CDB_valid && (CDB_tag == Q1_tag);
        q2_hit   = CDB_valid && (CDB_tag == Q2_tag);
        Q1_ready = busy_q[Q1_tag] && (ready_q[Q1_tag] || q1_hit);
        Q2_ready = busy_q[Q2_tag] && (ready_q[Q2_tag] || q2_hit);
        Q1_data  = q1_hit ? CDB_data : data_q[Q1_tag];
        Q2_data  = q2_hit ? CDB_data : data_q[Q2_tag];
    end
`else
    logic unused_query;

    assign Q1_ready     = 1'b0;
    assign Q2_ready     = 1'b0;
    assign Q1_data      = '0;
    assign Q2_data      = '0;
    assign unused_query = ^{Q1_tag, Q2_tag};
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - vector-table bench for reorder_buffer
module tb_reorder_buffer;

`ifdef ROB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b1;
    logic        ID_alloc_valid = 1'b0;
    logic [4:0]  ID_alloc_reg_dest = '0;
    logic [3:0]  ROB_alloc_tag;
    logic        ROB_full;
    logic        CDB_valid = 1'b0;
    logic [3:0]  CDB_tag = '0;
    logic [31:0] CDB_data = '0;
    logic        CDB_mispredict = 1'b0;
    logic [31:0] CDB_target_pc = '0;
    logic [3:0]  Q1_tag = '0;
    logic [3:0]  Q2_tag = '0;
    logic        Q1_ready, Q2_ready;
    logic [31:0] Q1_data, Q2_data;
    logic        ROB_data_valid;
    logic [4:0]  ROB_reg_dest;
    logic [3:0]  ROB_tag;
    logic [31:0] ROB_data;
    logic        ROB_flush;
    logic [31:0] ROB_flush_pc;

    int n_vec = 0;
    int n_err = 0;

    reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .ID_alloc_valid(ID_alloc_valid), .ID_alloc_reg_dest(ID_alloc_reg_dest),
        .ROB_alloc_tag(ROB_alloc_tag), .ROB_full(ROB_full),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .CDB_mispredict(CDB_mispredict), .CDB_target_pc(CDB_target_pc),
        .Q1_tag(Q1_tag), .Q2_tag(Q2_tag), .Q1_ready(Q1_ready), .Q2_ready(Q2_ready),
        .Q1_data(Q1_data), .Q2_data(Q2_data),
        .ROB_data_valid(ROB_data_valid), .ROB_reg_dest(ROB_reg_dest),
        .ROB_tag(ROB_tag), .ROB_data(ROB_data),
        .ROB_flush(ROB_flush), .ROB_flush_pc(ROB_flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  rd;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cd;
        logic        cm;
        logic [31:0] cpc;
        logic        chk_q;
        logic [3:0]  q1t;
        logic [3:0]  q2t;
        logic [3:0]  e_tag;
        logic        e_full;
        logic        e_q1r;
        logic [31:0] e_q1d;
        logic        e_q2r;
        logic [31:0] e_q2d;
        logic        e_dv;
        logic [4:0]  e_rd;
        logic [3:0]  e_ctag;
        logic [31:0] e_data;
        logic        e_fl;
        logic [31:0] e_fpc;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; ID_alloc_valid = 1'b0; ID_alloc_reg_dest = '0;
        CDB_valid = 1'b0; CDB_tag = '0; CDB_data = '0;
        CDB_mispredict = 1'b0; CDB_target_pc = '0;
        Q1_tag = '0; Q2_tag = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " dv"},       32'(ROB_data_valid), 32'h0);
        chk({tag, " rd"},       32'(ROB_reg_dest),   32'h0);
        chk({tag, " tag"},      32'(ROB_tag),        32'h0);
        chk({tag, " data"},     ROB_data,            32'h0);
        chk({tag, " flush"},    32'(ROB_flush),      32'h0);
        chk({tag, " flush_pc"}, ROB_flush_pc,        32'h0);
        chk({tag, " full"},     32'(ROB_full),       32'h0);
        chk({tag, " alloc_tag"},32'(ROB_alloc_tag),  32'h0);
        chk({tag, " q1_ready"}, 32'(Q1_ready),       32'h0);
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        // rst av rd cv ct cd cm cpc | chk q1t q2t | e_tag e_full e_q1r e_q1d e_q2r e_q2d | e_dv e_rd e_ctag e_data e_fl e_fpc
        vecs[0]  = '{1'b1,1'b1,5'd5,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[1]  = '{1'b0,1'b1,5'd6,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b1,5'd7,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd2,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b0,5'd0,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd3,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b0,5'd0,1'b1,4'd1,32'h11,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd3,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b0,5'd0,1'b1,4'd0,32'hAA,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd3,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[6]  = '{1'b0,1'b0,5'd0,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd3,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,5'd5,4'd0,32'hAA,1'b0,32'h0};
        vecs[7]  = '{1'b0,1'b0,5'd0,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd3,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,5'd6,4'd1,32'h11,1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b0,5'd0,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd3,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        // Mispredict flush with younger busy entries, plus operand queries
        vecs[9]  = '{1'b1,1'b1,5'd1,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[10] = '{1'b0,1'b1,5'd2,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[11] = '{1'b0,1'b1,5'd3,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd2,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b1,5'd4,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd3,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[13] = '{1'b0,1'b1,5'd5,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd4,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[14] = '{1'b0,1'b0,5'd0,1'b1,4'd4,32'h55,1'b0,32'h0, 1'b1,4'd4,4'd0, 4'd5,1'b0,BYP,(BYP ? 32'h55 : 32'h0),1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[15] = '{1'b0,1'b0,5'd0,1'b1,4'd0,32'hA0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd5,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[16] = '{1'b0,1'b0,5'd0,1'b1,4'd1,32'hA1,1'b0,32'h0, 1'b1,4'd0,4'd1, 4'd5,1'b0,BYP,(BYP ? 32'hA0 : 32'h0),BYP,(BYP ? 32'hA1 : 32'h0), 1'b1,5'd1,4'd0,32'hA0,1'b0,32'h0};
        vecs[17] = '{1'b0,1'b0,5'd0,1'b1,4'd2,32'hB2,1'b1,32'h1000, 1'b0,4'd0,4'd0, 4'd5,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,5'd2,4'd1,32'hA1,1'b0,32'h0};
        vecs[18] = '{1'b0,1'b1,5'd9,1'b1,4'd3,32'hC3,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd5,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,5'd3,4'd2,32'hB2,1'b1,32'h1000};
        vecs[19] = '{1'b0,1'b0,5'd0,1'b1,4'd4,32'hC4,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[20] = '{1'b0,1'b0,5'd0,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[21] = '{1'b0,1'b1,5'd12,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};
        vecs[22] = '{1'b0,1'b0,5'd0,1'b0,4'd0,32'h0,1'b0,32'h0, 1'b0,4'd0,4'd0, 4'd1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,5'd0,4'd0,32'h0,1'b0,32'h0};

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            rdy = 1'b1;
            ID_alloc_valid = vecs[i].av;  ID_alloc_reg_dest = vecs[i].rd;
            CDB_valid = vecs[i].cv;       CDB_tag = vecs[i].ct;  CDB_data = vecs[i].cd;
            CDB_mispredict = vecs[i].cm;  CDB_target_pc = vecs[i].cpc;
            Q1_tag = vecs[i].q1t;         Q2_tag = vecs[i].q2t;
            #3;
            chk($sformatf("v%0d alloc_tag", i), 32'(ROB_alloc_tag), 32'(vecs[i].e_tag));
            chk($sformatf("v%0d full", i), 32'(ROB_full), 32'(vecs[i].e_full));
            if (vecs[i].chk_q) begin
                chk($sformatf("v%0d q1_ready", i), 32'(Q1_ready), 32'(vecs[i].e_q1r));
                chk($sformatf("v%0d q1_data", i), Q1_data, vecs[i].e_q1d);
                chk($sformatf("v%0d q2_ready", i), 32'(Q2_ready), 32'(vecs[i].e_q2r));
                chk($sformatf("v%0d q2_data", i), Q2_data, vecs[i].e_q2d);
            end
            step();
            chk($sformatf("v%0d commit_valid", i), 32'(ROB_data_valid), 32'(vecs[i].e_dv));
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d commit_rd", i), 32'(ROB_reg_dest), 32'(vecs[i].e_rd));
                chk($sformatf("v%0d commit_tag", i), 32'(ROB_tag), 32'(vecs[i].e_ctag));
                chk($sformatf("v%0d commit_data", i), ROB_data, vecs[i].e_data);
            end
            chk($sformatf("v%0d flush", i), 32'(ROB_flush), 32'(vecs[i].e_fl));
            if (vecs[i].e_fl) begin
                chk($sformatf("v%0d flush_pc", i), ROB_flush_pc, vecs[i].e_fpc);
            end
        end

        // Fill to capacity, drop allocations while full, then wrap the tail.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ID_alloc_valid = 1'b1; ID_alloc_reg_dest = 5'(i + 1);
            #3;
            chk($sformatf("fill%0d alloc_tag", i), 32'(ROB_alloc_tag), 32'(i));
            chk($sformatf("fill%0d full", i), 32'(ROB_full), 32'h0);
            step();
        end
        ID_alloc_reg_dest = 5'd17;
        #3;
        chk("full set", 32'(ROB_full), 32'h1);
        step();
        chk("drop17 tail", 32'(ROB_alloc_tag), 32'h0);
        chk("drop17 full", 32'(ROB_full), 32'h1);
        ID_alloc_valid = 1'b0;
        CDB_valid = 1'b1; CDB_tag = 4'd0; CDB_data = 32'h100;
        step();
        chk("full cdb no commit", 32'(ROB_data_valid), 32'h0);
        CDB_valid = 1'b0;
        ID_alloc_valid = 1'b1; ID_alloc_reg_dest = 5'd20;
        #3;
        chk("alloc+commit full", 32'(ROB_full), 32'h1);
        step();
        chk("full commit dv", 32'(ROB_data_valid), 32'h1);
        chk("full commit tag", 32'(ROB_tag), 32'h0);
        chk("full commit rd", 32'(ROB_reg_dest), 32'h1);
        chk("full commit data", ROB_data, 32'h100);
        chk("freed full", 32'(ROB_full), 32'h0);
        chk("freed tail", 32'(ROB_alloc_tag), 32'h0);
        ID_alloc_reg_dest = 5'd21;
        step();
        chk("wrap tail", 32'(ROB_alloc_tag), 32'h1);
        chk("wrap full", 32'(ROB_full), 32'h1);
        chk("wrap no commit", 32'(ROB_data_valid), 32'h0);

        // rdy stall with a ready head, then asynchronous reset mid-stream.
        do_reset();
        ID_alloc_valid = 1'b1; ID_alloc_reg_dest = 5'd3;
        step();
        ID_alloc_valid = 1'b0;
        CDB_valid = 1'b1; CDB_tag = 4'd0; CDB_data = 32'h77;
        step();
        chk("pre-stall dv", 32'(ROB_data_valid), 32'h0);
        CDB_valid = 1'b0;
        rdy = 1'b0; ID_alloc_valid = 1'b1; ID_alloc_reg_dest = 5'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d dv", i), 32'(ROB_data_valid), 32'h0);
            chk($sformatf("stall%0d tail", i), 32'(ROB_alloc_tag), 32'h1);
        end
        rdy = 1'b1; ID_alloc_valid = 1'b0;
        step();
        chk("resume dv", 32'(ROB_data_valid), 32'h1);
        chk("resume tag", 32'(ROB_tag), 32'h0);
        chk("resume rd", 32'(ROB_reg_dest), 32'h3);
        chk("resume data", ROB_data, 32'h77);
        ID_alloc_valid = 1'b1; ID_alloc_reg_dest = 5'd4;
        step();
        ID_alloc_valid = 1'b0;
        CDB_valid = 1'b1; CDB_tag = 4'd1; CDB_data = 32'h88;
        step();
        CDB_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        step();
        rst_n = 1'b1;
        step();
        chk("post-reset dv", 32'(ROB_data_valid), 32'h0);
        chk("post-reset tail", 32'(ROB_alloc_tag), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer between decode/dispatch and the register file. It allocates one entry per decoded instruction and captures execution results from the common data bus (CDB). Entries retire strictly in program order, and each retirement is driven onto the register-file write-back port. A retiring mispredicted branch raises a one-cycle flush.

## Interface
Parameters:
- ROB_SIZE, 16, entry count; power of two, ≥2
- TAG_W, 4, log2(ROB_SIZE); width of every tag port

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when 0, no architectural state changes
- ID_alloc_valid  in  1  decode requests one entry this cycle
- ID_alloc_reg_dest  in  5  destination register; 0 means no write-back
- ROB_alloc_tag  out  TAG_W  combinational; equals tail pointer, the tag the next allocation receives
- ROB_full  out  1  combinational; count == ROB_SIZE
- CDB_valid  in  1  result broadcast
- CDB_tag  in  TAG_W  entry that produced the result
- CDB_data  in  32  result value
- CDB_mispredict  in  1  entry is a mispredicted branch
- CDB_target_pc  in  32  correct PC for a mispredicted branch
- Q1_tag, Q2_tag  in  TAG_W  dispatch operand queries
- Q1_ready, Q2_ready  out  1  queried entry holds a result
- Q1_data, Q2_data  out  32  queried entry's result
- ROB_data_valid  out  1  registered commit pulse to register file
- ROB_reg_dest  out  5  registered commit destination
- ROB_tag  out  TAG_W  registered commit tag
- ROB_data  out  32  registered commit value
- ROB_flush  out  1  registered one-cycle pipeline flush
- ROB_flush_pc  out  32  registered redirect PC

## Operation
- State: per-entry busy, ready, mispredict, reg_dest[4:0], data[31:0], target_pc[31:0]; head and tail pointers of TAG_W bits; count of TAG_W+1 bits.
- Allocate: when ID_alloc_valid && !ROB_full && rdy:
  - write entry[tail] with busy=1, ready=0, mispredict=0, reg_dest.
  - tail increments modulo ROB_SIZE.
- Allocation while full is dropped. Decode must hold the instruction.
- Complete: when CDB_valid && entry[CDB_tag].busy:
  - set ready=1 and store data, mispredict and target_pc.
  - A CDB write to a non-busy entry is ignored.
- Commit: when entry[head].busy && entry[head].ready && rdy, on the same edge:
  - ROB_data_valid ← 1; ROB_reg_dest, ROB_tag, ROB_data ← entry fields.
  - entry busy ← 0; head increments.
  - reg_dest 0 is still committed with ROB_reg_dest=0. The register file ignores it.
- Flush: a committing entry with mispredict=1 commits normally and, on the same edge:
  - sets ROB_flush=1 and ROB_flush_pc=target_pc.
  - clears every busy bit; head ← 0, tail ← 0, count ← 0.
  - drops any allocation and any CDB write in that cycle.
- Count: +1 on allocate, −1 on commit. Simultaneous allocate and commit leaves count unchanged and is legal when full: the freed slot is not reused the same cycle, because ROB_full is evaluated before commit.
- At most one commit per cycle.

## Timing
- Reset (rst_n=0, asynchronous): all outputs and all registered state are 0. ROB_full=0 and ROB_alloc_tag=0.
- Allocation-to-tag: ROB_alloc_tag is valid in the same cycle. The entry is busy after the edge.
- CDB-to-commit: a result written at edge N commits at edge N+1 at the earliest. ROB_data_valid is visible during the following cycle.
- ROB_data_valid and ROB_flush are single-cycle pulses. Each is forced to 0 on any edge with no commit or flush, including edges with rdy=0.
- rdy=0: pointers, count and entries hold. Pulse outputs go to 0.
- Wrap-around: pointers roll from ROB_SIZE−1 to 0 and tags reuse.
- Reset asserted mid-operation discards all entries immediately.

## Configuration
- ROB_BYPASS_EN defined:
  - Qn_ready = entry[Qn_tag].busy && (entry.ready || (CDB_valid && CDB_tag==Qn_tag)).
  - Qn_data is taken from the CDB when the CDB matches, otherwise from the entry.
  - Dispatch obtains finished-but-uncommitted operands without waiting.
- Undefined: Q1/Q2 ready and data are tied to 0, the query logic is not built, and dispatch relies solely on CDB snooping.

## Test plan
- Reset, then allocate 3 entries with rd=5,6,7 → ROB_alloc_tag 0,1,2,3 in successive cycles; count 3; no commit.
- CDB writes tag 1=0x11, then tag 0=0xAA → commits in order: tag 0 (rd5, 0xAA), then tag 1 (rd6, 0x11) on consecutive cycles.
- Allocate 16 with none completing → ROB_full=1; a 17th allocation is dropped and tail stays 0. Complete tag 0 → commit; next allocation takes tag 0 (wrap).
- Tag 2 completes with mispredict, target 0x1000, and younger tags 3–4 are busy → tag 2 commits. ROB_flush=1 with ROB_flush_pc=0x1000 for one cycle; next ROB_alloc_tag=0; tags 3–4 never commit.
- With ROB_BYPASS_EN: Q1_tag=4 while CDB writes tag 4=0x55 → Q1_ready=1, Q1_data=0x55 the same cycle. Without the macro → Q1_ready=0.
- Deassert rdy for 3 cycles with the head ready, then pull rst_n low mid-stream → no commit while rdy=0; all outputs 0 immediately on reset.
